// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding and widths for the DDS sweep controller.
//   Exports: FW_W_DEF (default tuning word width), STEP_SH_W (step_sel width),
//   S_IDLE..S_DONE state codes and the state_t enum built from them.
package dds_pkg;
   localparam int unsigned FW_W_DEF  = 32;
   localparam int unsigned STEP_SH_W = 2;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_UPD   = 3'd1;
   localparam logic [2:0] S_DWELL = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_UPD   = S_UPD,
      ST_DWELL = S_DWELL,
      ST_PAUSE = S_PAUSE,
      ST_DONE  = S_DONE
   } state_t;
endpackage

// File: rtl/dds_dwell_cnt.sv
// dds_dwell_cnt: dwell-time counter with clear/enable/hold and terminal count.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   clr_i              : synchronous clear to 0 (highest priority)
//   en_i               : count up by one this cycle
//   hold_i             : freeze the count even if en_i is set
//   cnt_o              : current count
//   tc_o               : high while cnt_o == DWELL_MAX
module dds_dwell_cnt #(
   parameter int unsigned DWELL_MAX = 4_999_999,
   localparam int unsigned CNT_W = (DWELL_MAX > 0) ? $clog2(DWELL_MAX + 1) : 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             hold_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign cnt_d = clr_i ? '0 : (en_i && !hold_i) ? cnt_q + 1'b1 : cnt_q;
   assign cnt_o = cnt_q;
   assign tc_o  = cnt_q == CNT_W'(DWELL_MAX);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear DDS tuning-word sweep between F_START and F_STOP,
// dwelling DWELL_MAX+1 cycles per step, single-shot or triangle loop.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   key_run            : pulse - start (idle) / pause (dwell) / resume (pause)
//   key_abort          : pulse - return to idle (deferred until an open transfer completes)
//   loop_en            : level - triangle loop at the top endpoint instead of finishing
//   step_sel           : step = F_STEP << step_sel, latched at start
//   freq_word/vld/rdy  : valid/ready hand-off of the tuning word to the DDS
//   sweep_busy         : high outside idle
//   sweep_done         : one-cycle pulse when a single-shot sweep finishes
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int unsigned     FW_W      = FW_W_DEF,
   parameter int unsigned     DWELL_MAX = 4_999_999,
   parameter logic [FW_W-1:0] F_START   = 32'd858_993,
   parameter logic [FW_W-1:0] F_STOP    = 32'd85_899_346,
   parameter logic [FW_W-1:0] F_STEP    = 32'd858_993
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 key_run,
   input  logic                 key_abort,
   input  logic                 loop_en,
   input  logic [STEP_SH_W-1:0] step_sel,
   output logic [FW_W-1:0]      freq_word,
   output logic                 freq_vld,
   input  logic                 freq_rdy,
   output logic                 sweep_busy,
   output logic                 sweep_done
);
   state_t          state_q, state_d;
   logic [FW_W-1:0] word_q, word_d, step_q, step_d, up_w, dn_w;
   logic            dir_q, dir_d, abort_q, abort_d, tc;
   logic [FW_W:0]   sum, diff;

   // One extra bit so the clamp sees overflow/borrow instead of a wrapped word.
   assign sum  = {1'b0, word_q} + {1'b0, step_q};
   assign diff = {1'b0, word_q} - {1'b0, step_q};
   assign up_w = (sum > {1'b0, F_STOP}) ? F_STOP : sum[FW_W-1:0];
   assign dn_w = (diff[FW_W] || diff[FW_W-1:0] < F_START) ? F_START : diff[FW_W-1:0];

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      dir_d   = dir_q;
      step_d  = step_q;
      abort_d = abort_q;
      case (state_q)
         ST_IDLE: if (key_run && !key_abort) begin
            step_d  = F_STEP << step_sel;
            word_d  = F_START;
            dir_d   = 1'b1;
            abort_d = 1'b0;
            state_d = ST_UPD;
         end
         ST_UPD: begin
            // Abort must not break an open handshake; remember it until transfer.
            abort_d = abort_q || key_abort;
            if (freq_rdy) begin
               abort_d = 1'b0;
               state_d = (abort_q || key_abort) ? ST_IDLE : ST_DWELL;
               word_d  = (abort_q || key_abort) ? F_START : word_q;
            end
         end
         ST_DWELL: begin
            if (key_abort) begin
               state_d = ST_IDLE;
               word_d  = F_START;
            end else if (key_run) begin
               state_d = ST_PAUSE;
            end else if (tc) begin
               state_d = ST_UPD;
               if (dir_q && word_q == F_STOP) begin
                  dir_d   = !loop_en;
                  word_d  = loop_en ? dn_w : F_START;
                  state_d = loop_en ? ST_UPD : ST_DONE;
               end else if (!dir_q && word_q == F_START) begin
                  dir_d  = 1'b1;
                  word_d = up_w;
               end else begin
                  word_d = dir_q ? up_w : dn_w;
               end
            end
         end
         ST_PAUSE: begin
            state_d = key_abort ? ST_IDLE : key_run ? ST_DWELL : ST_PAUSE;
            word_d  = key_abort ? F_START : word_q;
         end
         ST_DONE: state_d = ST_IDLE;
         default: begin
            state_d = ST_IDLE;
            word_d  = F_START;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         word_q  <= F_START;
         dir_q   <= 1'b1;
         step_q  <= F_STEP;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         abort_q <= abort_d;
      end
   end

   // Count only on cycles that stay in DWELL, so the pause and resume cycles
   // leave the count untouched; anything outside DWELL/PAUSE restarts at 0.
   dds_dwell_cnt #(.DWELL_MAX(DWELL_MAX)) u_dwell (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .clr_i    (!(state_d inside {ST_DWELL, ST_PAUSE})),
      .en_i     (state_q == ST_DWELL && state_d == ST_DWELL),
      .hold_i   (state_q == ST_PAUSE),
      .cnt_o    (),
      .tc_o     (tc)
   );

   assign freq_word  = word_q;
   assign freq_vld   = state_q == ST_UPD;
   assign sweep_busy = state_q != ST_IDLE;
   assign sweep_done = state_q == ST_DONE;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed scenarios plus random stimulus against a behavioural sweep model.
module tb_dds_sweep_ctrl;
   localparam longint TB_START = 10;
   localparam longint TB_STOP  = 40;
   localparam longint TB_STEP  = 10;
   localparam int     TB_DW    = 3;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        key_run = 1'b0, key_abort = 1'b0, loop_en = 1'b0, freq_rdy = 1'b0;
   logic [1:0]  step_sel = 2'd0;
   logic [31:0] freq_word;
   logic        freq_vld, sweep_busy, sweep_done;

   int checks = 0, failures = 0, done_cnt = 0;
   longint acc[$];

   always #5 clk = ~clk;

   dds_sweep_ctrl #(
      .FW_W(32), .DWELL_MAX(TB_DW),
      .F_START(32'(TB_START)), .F_STOP(32'(TB_STOP)), .F_STEP(32'(TB_STEP))
   ) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .key_run(key_run), .key_abort(key_abort),
      .loop_en(loop_en), .step_sel(step_sel), .freq_word(freq_word), .freq_vld(freq_vld),
      .freq_rdy(freq_rdy), .sweep_busy(sweep_busy), .sweep_done(sweep_done)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
      end
   endtask

   // Model phases: 0 idle, 1 offering a word, 2 dwelling, 3 paused, 4 finished.
   int     m_ph = 0, m_dw = 0;
   longint m_word = TB_START, m_step = TB_STEP;
   bit     m_up = 1'b1, m_pend = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= 0; m_dw <= 0; m_word <= TB_START; m_step <= TB_STEP; m_up <= 1'b1; m_pend <= 1'b0;
      end else begin : mdl
         int ph, dw;
         longint w, st;
         bit up, pend;
         ph = m_ph; dw = m_dw; w = m_word; st = m_step; up = m_up; pend = m_pend;
         if (ph == 0) begin
            if (key_run && !key_abort) begin
               st = TB_STEP * (longint'(1) << step_sel); w = TB_START; up = 1'b1; pend = 1'b0; ph = 1;
            end
         end else if (ph == 1) begin
            pend = pend | key_abort;
            if (freq_rdy) begin
               if (pend) begin ph = 0; w = TB_START; end
               else begin ph = 2; dw = 0; end
               pend = 1'b0;
            end
         end else if (ph == 2) begin
            if (key_abort) begin ph = 0; w = TB_START; end
            else if (key_run) ph = 3;
            else if (dw < TB_DW) dw++;
            else begin
               ph = 1;
               if (up && w == TB_STOP) begin
                  if (loop_en) begin up = 1'b0; w = (TB_STOP - st < TB_START) ? TB_START : TB_STOP - st; end
                  else begin w = TB_START; ph = 4; end
               end else if (!up && w == TB_START) begin
                  up = 1'b1; w = (TB_START + st > TB_STOP) ? TB_STOP : TB_START + st;
               end else if (up) w = (w + st > TB_STOP) ? TB_STOP : w + st;
               else w = (w - st < TB_START) ? TB_START : w - st;
            end
         end else if (ph == 3) begin
            if (key_abort) begin ph = 0; w = TB_START; end
            else if (key_run) ph = 2;
         end else ph = 0;
         m_ph <= ph; m_dw <= dw; m_word <= w; m_step <= st; m_up <= up; m_pend <= pend;
      end
   end

   // Outputs and freq_rdy are all stable at the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("word", freq_word, m_word);
         chk("vld", freq_vld, m_ph == 1);
         chk("busy", sweep_busy, m_ph != 0);
         chk("done", sweep_done, m_ph == 4);
         chk("range", (freq_word >= TB_START && freq_word <= TB_STOP), 1);
         if (sweep_done) done_cnt++;
         if (freq_vld && freq_rdy) acc.push_back(freq_word);
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_run();
      key_run = 1'b1; cyc(); key_run = 1'b0;
   endtask

   task automatic pulse_abort();
      key_abort = 1'b1; cyc(); key_abort = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n = 0;
      while (sweep_busy && n < budget) begin cyc(); n++; end
      chk({nm, "_idle_timeout"}, sweep_busy, 0);
   endtask

   task automatic clr_log();
      acc.delete();
      done_cnt = 0;
   endtask

   initial begin
      repeat (3) cyc();
      rst_n = 1'b1;
      chk("rst_word", freq_word, 10);
      chk("rst_vld", freq_vld, 0);
      chk("rst_busy", sweep_busy, 0);
      chk("rst_done", sweep_done, 0);

      // 1: single-shot, unit step
      freq_rdy = 1'b1; clr_log();
      pulse_run();
      wait_idle("t1", 100);
      chk("t1_n", acc.size(), 4);
      for (int i = 0; i < 4 && i < acc.size(); i++) chk("t1_w", acc[i], 10 * (i + 1));
      chk("t1_done", done_cnt, 1);
      chk("t1_word", freq_word, 10);

      // 2: step 40 clamps at the top endpoint
      step_sel = 2'd2; clr_log();
      pulse_run();
      step_sel = 2'd0;
      wait_idle("t2", 100);
      chk("t2_n", acc.size(), 2);
      if (acc.size() == 2) begin chk("t2_w0", acc[0], 10); chk("t2_w1", acc[1], 40); end
      chk("t2_done", done_cnt, 1);

      // 3: triangle loop, then abort
      loop_en = 1'b1; clr_log();
      pulse_run();
      begin
         int n = 0;
         while (acc.size() < 8 && n < 300) begin cyc(); n++; end
      end
      chk("t3_n", acc.size() >= 8, 1);
      if (acc.size() >= 8) begin
         longint exp_seq[8] = '{10, 20, 30, 40, 30, 20, 10, 20};
         for (int i = 0; i < 8; i++) chk("t3_w", acc[i], exp_seq[i]);
      end
      chk("t3_done", done_cnt, 0);
      pulse_abort();
      chk("t3_abort_busy", sweep_busy, 0);
      loop_en = 1'b0;

      // 4: DDS stalls for 5 cycles
      freq_rdy = 1'b0;
      pulse_run();
      for (int i = 0; i < 5; i++) begin
         chk("t4_vld", freq_vld, 1);
         chk("t4_word", freq_word, 10);
         if (i < 4) cyc();
      end
      freq_rdy = 1'b1;
      cyc();
      chk("t4_dwell_vld", freq_vld, 0);
      chk("t4_dwell_busy", sweep_busy, 1);
      pulse_abort();

      // 5: pause at cnt=1, resume, run ignored during transfer
      pulse_run();
      cyc(); cyc();
      pulse_run();
      repeat (10) begin cyc(); chk("t5_pause_vld", freq_vld, 0); end
      pulse_run();
      freq_rdy = 1'b0;
      begin
         int n = 0;
         while (!freq_vld && n < 20) begin cyc(); n++; end
         chk("t5_resume_len", n, 3);
      end
      pulse_run();
      chk("t5_upd_vld", freq_vld, 1);
      chk("t5_upd_word", freq_word, 20);
      freq_rdy = 1'b1;
      cyc();
      chk("t5_after_vld", freq_vld, 0);
      pulse_abort();

      // 6a: abort during a stalled transfer
      freq_rdy = 1'b0;
      pulse_run();
      pulse_abort();
      chk("t6_hold_vld", freq_vld, 1);
      cyc();
      chk("t6_hold_vld2", freq_vld, 1);
      freq_rdy = 1'b1;
      cyc();
      chk("t6_abort_busy", sweep_busy, 0);
      chk("t6_abort_vld", freq_vld, 0);
      // 6b: abort and run together in dwell
      pulse_run(); cyc(); cyc();
      key_run = 1'b1; key_abort = 1'b1; cyc(); key_run = 1'b0; key_abort = 1'b0;
      chk("t6_both_busy", sweep_busy, 0);
      // 6c: asynchronous reset mid-dwell
      step_sel = 2'd1;
      pulse_run(); cyc(); cyc(); cyc();
      @(negedge clk); #3 rst_n = 1'b0;
      #1;
      chk("t6_arst_word", freq_word, 10);
      chk("t6_arst_vld", freq_vld, 0);
      chk("t6_arst_busy", sweep_busy, 0);
      chk("t6_arst_done", sweep_done, 0);
      cyc(); cyc();
      rst_n = 1'b1;

      // random stimulus
      for (int i = 0; i < 3000; i++) begin
         key_run   = ($urandom_range(0, 15) == 0);
         key_abort = ($urandom_range(0, 63) == 0);
         freq_rdy  = ($urandom_range(0, 9) < 7);
         step_sel  = 2'($urandom);
         if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
         cyc();
      end
      key_run = 1'b0; key_abort = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
